// File: rtl/i2c_slave_byte_if.sv
// i2c_slave_byte_if
//   Pin and user-side bundle for the i2c_slave_byte target.
//   Bus side (open drain, resolved outside the target):
//     sda_i / scl_i   : resolved bus levels seen by the target
//     sda_o / scl_o   : output levels, always 0 (open drain)
//     sda_oe / scl_oe : 1 = pull the line low (scl_oe is always 0)
//   User side:
//     wr_data_o / wr_valid_o : received write byte and its one-cycle strobe
//     rd_data_i / rd_req_o   : byte to transmit and its one-cycle consume strobe
//     busy_o                 : target currently addressed
//     start_o                : one-cycle pulse per START / repeated START
//   Modports: slave (the target), master (bus driver plus user logic).
interface i2c_slave_byte_if;
  logic       sda_i;
  logic       sda_o;
  logic       sda_oe;
  logic       scl_i;
  logic       scl_o;
  logic       scl_oe;
  logic [7:0] wr_data_o;
  logic       wr_valid_o;
  logic [7:0] rd_data_i;
  logic       rd_req_o;
  logic       busy_o;
  logic       start_o;

  modport slave (
    input  sda_i, scl_i, rd_data_i,
    output sda_o, sda_oe, scl_o, scl_oe, wr_data_o, wr_valid_o, rd_req_o, busy_o, start_o
  );

  modport master (
    output sda_i, scl_i, rd_data_i,
    input  sda_o, sda_oe, scl_o, scl_oe, wr_data_o, wr_valid_o, rd_req_o, busy_o, start_o
  );
endinterface

// File: rtl/i2c_slave_byte.sv
// i2c_slave_byte
//   I2C target answering one 7-bit address. SCL/SDA are oversampled on clk_i
//   (clk_i must be at least 20x the SCL frequency); START/STOP are detected
//   from the synchronized levels and override every state. Received write
//   bytes are streamed out on wr_data_o/wr_valid_o; read bytes are fetched
//   from rd_data_i with a one-cycle rd_req_o pulse per byte. No clock
//   stretching: scl_oe and both output levels are tied to 0.
//   Ports:
//     clk_i : system clock
//     rst_i : synchronous, active-high reset
//     bus   : i2c_slave_byte_if.slave (bus pins and user handshake)
//   Parameters:
//     SLAVE_ADDR : 7-bit target address (default 7'h39)
//     FILTER_LEN : glitch filter length in clk_i cycles, present only when
//                  I2C_GLITCH_FILTER_EN is defined
//   Build option:
//     I2C_GLITCH_FILTER_EN : when defined, each synchronized line must hold
//     a new level for FILTER_LEN consecutive samples before it is accepted.
module i2c_slave_byte #(
  parameter logic [6:0] SLAVE_ADDR = 7'h39
`ifdef I2C_GLITCH_FILTER_EN
  ,
  parameter int FILTER_LEN = 4
`endif
) (
  input logic             clk_i,
  input logic             rst_i,
  i2c_slave_byte_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  logic   sda_s1_r, sda_s2_r, scl_s1_r, scl_s2_r;
  logic   sda_f_s, scl_f_s;
  logic   sda_d_r, scl_d_r;
  logic   scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_r, state_n;
  logic [3:0] bit_cnt_r, bit_cnt_n;
  logic [7:0] shift_r, shift_n;
  logic       sda_oe_r, sda_oe_n;
  logic       busy_r, busy_n;
  logic [7:0] wr_data_r, wr_data_n;
  logic       wr_valid_r, wr_valid_n;
  logic       rd_req_r, rd_req_n;
  logic       start_r, start_n;

  // Two-flop synchronizers; reset to the idle-bus level so no edge is seen at reset release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sda_s1_r <= 1'b1;
      sda_s2_r <= 1'b1;
      scl_s1_r <= 1'b1;
      scl_s2_r <= 1'b1;
    end else begin
      sda_s1_r <= bus.sda_i;
      sda_s2_r <= sda_s1_r;
      scl_s1_r <= bus.scl_i;
      scl_s2_r <= scl_s1_r;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic           sda_flt_r, scl_flt_r;
  logic [FCW-1:0] sda_cnt_r, scl_cnt_r;

  // Glitch filter: a line flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sda_flt_r <= 1'b1;
      scl_flt_r <= 1'b1;
      sda_cnt_r <= '0;
      scl_cnt_r <= '0;
    end else begin
      if (sda_s2_r == sda_flt_r) begin
        sda_cnt_r <= '0;
      end else if (sda_cnt_r == FCW'(FILTER_LEN - 1)) begin
        sda_flt_r <= sda_s2_r;
        sda_cnt_r <= '0;
      end else begin
        sda_cnt_r <= sda_cnt_r + FCW'(1);
      end
      if (scl_s2_r == scl_flt_r) begin
        scl_cnt_r <= '0;
      end else if (scl_cnt_r == FCW'(FILTER_LEN - 1)) begin
        scl_flt_r <= scl_s2_r;
        scl_cnt_r <= '0;
      end else begin
        scl_cnt_r <= scl_cnt_r + FCW'(1);
      end
    end
  end

  assign sda_f_s = sda_flt_r;
  assign scl_f_s = scl_flt_r;
`else
  assign sda_f_s = sda_s2_r;
  assign scl_f_s = scl_s2_r;
`endif

  // Previous accepted levels for edge and START/STOP detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sda_d_r <= 1'b1;
      scl_d_r <= 1'b1;
    end else begin
      sda_d_r <= sda_f_s;
      scl_d_r <= scl_f_s;
    end
  end

  assign scl_rise_s = scl_f_s & ~scl_d_r;
  assign scl_fall_s = ~scl_f_s & scl_d_r;
  assign start_s    = scl_f_s & scl_d_r & sda_d_r & ~sda_f_s;
  assign stop_s     = scl_f_s & scl_d_r & ~sda_d_r & sda_f_s;

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'd0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      wr_data_r  <= 8'd0;
      wr_valid_r <= 1'b0;
      rd_req_r   <= 1'b0;
      start_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      sda_oe_r   <= sda_oe_n;
      busy_r     <= busy_n;
      wr_data_r  <= wr_data_n;
      wr_valid_r <= wr_valid_n;
      rd_req_r   <= rd_req_n;
      start_r    <= start_n;
    end
  end

  // Next-state logic. Bits are sampled on SCL rise; SDA only changes on SCL fall.
  always_comb begin
    state_n    = state_r;
    bit_cnt_n  = bit_cnt_r;
    shift_n    = shift_r;
    sda_oe_n   = sda_oe_r;
    busy_n     = busy_r;
    wr_data_n  = wr_data_r;
    wr_valid_n = 1'b0;
    rd_req_n   = 1'b0;
    start_n    = 1'b0;
    if (start_s) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      shift_n   = 8'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      start_n   = 1'b1;
    end else if (stop_s) begin
      state_n   = IDLE;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state_r)
        IDLE, WAIT_STOP: begin
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
        ADDR: begin
          // bit_cnt_r == 8 marks a complete address byte waiting for the ACK slot.
          if (scl_rise_s && (bit_cnt_r != 4'd8)) begin
            shift_n   = {shift_r[6:0], sda_f_s};
            bit_cnt_n = bit_cnt_r + 4'd1;
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            if (shift_r[7:1] == SLAVE_ADDR) begin
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
              state_n  = ADDR_ACK;
            end else begin
              state_n = WAIT_STOP;
            end
          end else begin
            state_n = ADDR;
          end
        end
        ADDR_ACK: begin
          // shift_r[0] still holds the R/W bit of the address byte.
          if (scl_fall_s) begin
            bit_cnt_n = 4'd0;
            if (shift_r[0] == 1'b0) begin
              sda_oe_n = 1'b0;
              state_n  = WR_DATA;
            end else begin
              rd_req_n = 1'b1;
              shift_n  = bus.rd_data_i;
              sda_oe_n = ~bus.rd_data_i[7];
              state_n  = RD_DATA;
            end
          end else begin
            state_n = ADDR_ACK;
          end
        end
        WR_DATA: begin
          if (scl_rise_s && (bit_cnt_r != 4'd8)) begin
            shift_n   = {shift_r[6:0], sda_f_s};
            bit_cnt_n = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7) begin
              wr_data_n  = {shift_r[6:0], sda_f_s};
              wr_valid_n = 1'b1;
            end else begin
              wr_valid_n = 1'b0;
            end
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            sda_oe_n = 1'b1;
            state_n  = WR_ACK;
          end else begin
            state_n = WR_DATA;
          end
        end
        WR_ACK: begin
          if (scl_fall_s) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = WR_DATA;
          end else begin
            state_n = WR_ACK;
          end
        end
        RD_DATA: begin
          // bit_cnt_r counts bits already clocked out; shift_r[7] is on the bus.
          if (scl_fall_s) begin
            if (bit_cnt_r == 4'd7) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = 4'd0;
              state_n   = RD_ACK;
            end else begin
              shift_n   = {shift_r[6:0], 1'b0};
              sda_oe_n  = ~shift_r[6];
              bit_cnt_n = bit_cnt_r + 4'd1;
            end
          end else begin
            state_n = RD_DATA;
          end
        end
        RD_ACK: begin
          // bit_cnt_r == 1 records that the master ACKed and the next byte is due.
          if (scl_rise_s) begin
            if (sda_f_s) begin
              busy_n  = 1'b0;
              state_n = WAIT_STOP;
            end else begin
              bit_cnt_n = 4'd1;
            end
          end else if (scl_fall_s && (bit_cnt_r == 4'd1)) begin
            rd_req_n  = 1'b1;
            shift_n   = bus.rd_data_i;
            sda_oe_n  = ~bus.rd_data_i[7];
            bit_cnt_n = 4'd0;
            state_n   = RD_DATA;
          end else begin
            state_n = RD_ACK;
          end
        end
        default: begin
          state_n   = IDLE;
          bit_cnt_n = 4'd0;
          sda_oe_n  = 1'b0;
          busy_n    = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_o      = 1'b0;
  assign bus.scl_o      = 1'b0;
  assign bus.scl_oe     = 1'b0;
  assign bus.sda_oe     = sda_oe_r;
  assign bus.busy_o     = busy_r;
  assign bus.wr_data_o  = wr_data_r;
  assign bus.wr_valid_o = wr_valid_r;
  assign bus.rd_req_o   = rd_req_r;
  assign bus.start_o    = start_r;

endmodule

// File: tb/tb_i2c_slave_byte.sv
// tb_i2c_slave_byte
//   Bus-level master model plus user-side model for i2c_slave_byte.
//   Expected write bytes are queued before they are sent; a monitor pops
//   and compares them whenever wr_valid_o pulses. Read bytes come from a
//   source array that user logic walks one entry per rd_req_o pulse.
module tb_i2c_slave_byte;
  localparam logic [6:0] SLAVE_ADDR = 7'h39;
  localparam int QTR = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_sda = 1'b1;
  logic m_scl = 1'b1;

  i2c_slave_byte_if bus ();

  i2c_slave_byte #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Open-drain resolution: a line is low if either side pulls it.
  assign bus.sda_i = m_sda & ~bus.sda_oe;
  assign bus.scl_i = m_scl & ~bus.scl_oe;

  logic [7:0] rd_src [0:63];
  int         rd_mon_idx = 0;
  assign bus.rd_data_i = rd_src[rd_mon_idx];

  int n_chk = 0, n_fail = 0;
  int start_cnt = 0, rd_cnt = 0, wr_cnt = 0, oe_cycles = 0;
  int exp_starts = 0, exp_rd = 0, exp_wr = 0, rd_exp_idx = 0;
  logic [7:0] exp_wr_q[$];
  logic [7:0] wbuf [0:7];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: scores DUT strobes against the expectation queue and models the read source.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.sda_oe) oe_cycles++;
      if (bus.start_o) start_cnt++;
      if (bus.wr_valid_o) begin
        wr_cnt++;
        chk("wr_busy", {31'd0, bus.busy_o}, 32'd1);
        chk("wr_rd_excl", {31'd0, bus.rd_req_o}, 32'd0);
        if (exp_wr_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL wr_data: got 0x%02h, required no write strobe", bus.wr_data_o);
        end else begin
          chk("wr_data", {24'd0, bus.wr_data_o}, {24'd0, exp_wr_q.pop_front()});
        end
      end
      if (bus.rd_req_o) begin
        rd_cnt++;
        chk("rd_busy", {31'd0, bus.busy_o}, 32'd1);
        rd_mon_idx++;
      end
    end
  end

  // Watchdog: the run is a fixed sequence, so this only fires on a hang.
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic q();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
    exp_starts++;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask

  // One SCL clock: data set during low phase, resolved SDA sampled mid-high.
  task automatic clk_bit(input logic b, input logic spike, output logic seen);
    m_sda = b;
    if (spike) begin
      repeat (4) @(negedge clk);
      m_scl = 1'b1;
      repeat (2) @(negedge clk);
      m_scl = 1'b0;
      repeat (QTR - 6) @(negedge clk);
    end else begin
      q();
    end
    m_scl = 1'b1; q();
    seen = bus.sda_i; q();
    m_scl = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] b, input int spike_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], (i == spike_bit), s);
    clk_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      b[i] = s;
    end
    clk_bit(~give_ack, 1'b0, s);
  endtask

  task automatic do_write(input logic [6:0] addr, input int n, input int spike_bit, input logic do_stop);
    logic match, ack;
    int   oe0;
    match = (addr == SLAVE_ADDR);
    oe0 = oe_cycles;
    bus_start();
    write_byte({addr, 1'b0}, -1, ack);
    chk("wr_addr_ack", {31'd0, ack}, {31'd0, match});
    for (int i = 0; i < n; i++) begin
      if (match) begin
        exp_wr_q.push_back(wbuf[i]);
        exp_wr++;
      end
      write_byte(wbuf[i], (i == 0) ? spike_bit : -1, ack);
      chk("wr_data_ack", {31'd0, ack}, {31'd0, match});
    end
    chk("busy_after_write", {31'd0, bus.busy_o}, {31'd0, match});
    if (!match) chk("quiet_sda_wr", oe_cycles - oe0, 32'd0);
    if (do_stop) begin
      bus_stop();
      chk("busy_after_stop", {31'd0, bus.busy_o}, 32'd0);
    end
  endtask

  task automatic do_read(input logic [6:0] addr, input int n);
    logic       match, ack;
    logic [7:0] b;
    int         oe0;
    match = (addr == SLAVE_ADDR);
    oe0 = oe_cycles;
    bus_start();
    write_byte({addr, 1'b1}, -1, ack);
    chk("rd_addr_ack", {31'd0, ack}, {31'd0, match});
    if (match) begin
      for (int i = 0; i < n; i++) begin
        read_byte(i < n - 1, b);
        chk("rd_data", {24'd0, b}, {24'd0, rd_src[rd_exp_idx]});
        rd_exp_idx++;
        exp_rd++;
      end
    end else begin
      chk("quiet_sda_rd", oe_cycles - oe0, 32'd0);
    end
    chk("busy_after_nack", {31'd0, bus.busy_o}, 32'd0);
    bus_stop();
  endtask

  initial begin
    logic       ack;
    logic [6:0] a;
    int         s0;
    for (int i = 0; i < 64; i++) rd_src[i] = 8'($urandom_range(0, 255));
    rd_src[0] = 8'hA5;
    rd_src[1] = 8'h3C;
    rd_src[2] = 8'h80;
    rd_src[3] = 8'h00;

    repeat (4) @(negedge clk);
    chk("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_strobes", {29'd0, bus.wr_valid_o, bus.rd_req_o, bus.start_o}, 32'd0);
    chk("rst_wr_data", {24'd0, bus.wr_data_o}, 32'd0);
    rst = 1'b0;
    q();

    // Address-only write.
    do_write(SLAVE_ADDR, 0, -1, 1'b1);
    // Two-byte write.
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    do_write(SLAVE_ADDR, 2, -1, 1'b1);
    // Two-byte read, ACK then NACK.
    do_read(SLAVE_ADDR, 2);
    // Foreign address 0x52.
    s0 = start_cnt;
    do_write(7'h52, 0, -1, 1'b1);
    chk("foreign_starts", start_cnt - s0, 32'd1);
    // Write then repeated START into a read.
    s0 = start_cnt;
    wbuf[0] = 8'h11;
    do_write(SLAVE_ADDR, 1, -1, 1'b0);
    do_read(SLAVE_ADDR, 1);
    chk("rs_starts", start_cnt - s0, 32'd2);

    // Reset while the target drives a 0 data bit.
    bus_start();
    write_byte({SLAVE_ADDR, 1'b1}, -1, ack);
    chk("rst_rd_ack", {31'd0, ack}, 32'd1);
    exp_rd++;
    rd_exp_idx++;
    chk("rd_drive_zero", {31'd0, bus.sda_oe}, 32'd1);
    m_scl = 1'b1; q();
    rst = 1'b1;
    @(negedge clk);
    chk("sda_release_on_rst", {31'd0, bus.sda_oe}, 32'd0);
    rst = 1'b0;
    m_sda = 1'b1;
    q();
    chk("busy_after_rst", {31'd0, bus.busy_o}, 32'd0);
    do_write(SLAVE_ADDR, 0, -1, 1'b1);

`ifdef I2C_GLITCH_FILTER_EN
    // Short SCL spike inside a data byte must not add a bit.
    wbuf[0] = 8'h96;
    do_write(SLAVE_ADDR, 1, 3, 1'b1);
`endif

    // Randomized transactions.
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = SLAVE_ADDR;
      end else begin
        a = 7'($urandom_range(0, 127));
        if (a == SLAVE_ADDR) a = a ^ 7'h01;
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom_range(0, 255));
        do_write(a, $urandom_range(1, 3), -1, 1'b1);
      end else begin
        do_read(a, $urandom_range(1, 3));
      end
    end

    q();
    chk("start_count", start_cnt, exp_starts);
    chk("rd_req_count", rd_cnt, exp_rd);
    chk("wr_valid_count", wr_cnt, exp_wr);
    chk("wr_queue_drained", exp_wr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_byte.md
Name: i2c_slave_byte

Overview:
Synthesizable I2C target (responder) that answers a single 7-bit address on the open-drain bus through the same internal pin bundle the master model drives: sda_o/sda_i/sda_oe, scl_o/scl_i/scl_oe. Oversamples SCL/SDA on the system clock and detects START/STOP. Shifts bytes in and out and generates or samples ACK. Presents a byte-level write stream and read-request handshake to user logic. Sits behind the external connector, facing the bus.

Parameters:
SLAVE_ADDR, 7'h39, 7-bit target address; write frame byte 0x72, read frame byte 0x73
FILTER_LEN, 4, clk_i cycles a synchronized SDA/SCL level must persist before acceptance; used only with the optional feature

Ports:
clk_i  input  1  system clock; must be >= 20x SCL frequency
rst_i  input  1  synchronous, active-high reset
sda_i  input  1  bus SDA level
sda_o  output 1  constant 0 (open drain)
sda_oe  output 1  1 = pull SDA low
scl_i  input  1  bus SCL level
scl_o  output 1  constant 0
scl_oe  output 1  constant 0; no clock stretching
wr_data_o  output 8  byte received in a write transfer
wr_valid_o  output 1  one-cycle pulse; wr_data_o valid
rd_data_i  input 8  byte to transmit; sampled when rd_req_o is high
rd_req_o  output 1  one-cycle pulse; rd_data_i consumed, user advances to next byte
busy_o  output 1  high while addressed (address ACKed until STOP/new START/NACK)
start_o  output 1  one-cycle pulse on every START or repeated START

Behaviour:
- Input path: 2-FF synchronizers on sda_i and scl_i. Edge detect on synchronized SCL. All bus timing refers to synchronized values.
- START: SDA 1->0 while SCL high. STOP: SDA 0->1 while SCL high. Either one overrides every state in the same cycle it is detected.
- Reset: all outputs 0, state IDLE, shift register 0, bit counter 0. Reset mid-transfer releases SDA immediately.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE/WAIT_STOP: SDA released. START -> ADDR. start_o pulses on the START and bit counter clears.
- Bits are sampled on SCL rising edges, MSB first. Slave changes SDA only on SCL falling edges.
- ADDR: after the 8th rising edge, compare bits[7:1] with SLAVE_ADDR.
  - Mismatch -> WAIT_STOP; SDA never driven.
  - Match -> at the next falling edge assert sda_oe, set busy_o, enter ADDR_ACK.
- ADDR_ACK: at the falling edge ending the ACK clock:
  - R/W=0 -> release SDA, enter WR_DATA.
  - R/W=1 -> pulse rd_req_o, latch rd_data_i, drive bit 7 (sda_oe = ~bit), enter RD_DATA.
- WR_DATA: after 8 bits, wr_data_o updates and wr_valid_o pulses in the same cycle. Next falling edge asserts sda_oe (ACK) -> WR_ACK. Every byte is ACKed. Following falling edge releases SDA -> WR_DATA.
- RD_DATA: on each falling edge shift out the next bit. After bit 0's clock, the falling edge releases SDA -> RD_ACK.
- RD_ACK: master's bit is sampled on the rising edge.
  - 0 (ACK) -> at the falling edge pulse rd_req_o, latch the new byte, drive its MSB -> RD_DATA.
  - 1 (NACK) -> WAIT_STOP, busy_o low.
- Repeated START in any state: SDA released the same cycle, busy_o low, start_o pulses, -> ADDR.
- STOP in any state: SDA released, busy_o low -> IDLE. A partial byte is discarded; no wr_valid_o.
- wr_valid_o and rd_req_o never assert in the same cycle and never assert outside busy_o.

Optional Feature:
I2C_GLITCH_FILTER_EN
- Defined: after the synchronizers, each line passes a filter. It changes its output only after FILTER_LEN consecutive identical samples. Adds FILTER_LEN cycles of latency to all bus events.
- Undefined: no filter; synchronizer outputs feed edge/START/STOP detection directly.

Test Plan:
- START, 0x72, STOP -> ACK on 9th clock (sda_oe=1 for exactly that SCL period); busy_o high from ACK to STOP; no wr_valid_o.
- START, 0x72, 0x5A, 0xC3, STOP -> wr_valid_o pulses twice with wr_data_o 0x5A then 0xC3; both bytes ACKed.
- START, 0x73, rd_data_i=0xA5 then 0x3C, master ACKs byte 1 and NACKs byte 2, STOP -> bus shows 0xA5, 0x3C; rd_req_o pulses exactly twice; SDA released after NACK.
- START, 0xA4 (address 0x52), STOP -> SDA never driven low by the slave; busy_o stays 0; start_o pulses once.
- START, 0x72, 0x11, repeated START, 0x73, read one byte 0x80 with NACK, STOP -> one wr_valid_o (0x11), start_o pulses twice, read returns 0x80.
- rst_i asserted mid-read while driving a 0 bit -> sda_oe 0 the next cycle; the following START, 0x72 is ACKed normally. With I2C_GLITCH_FILTER_EN, a 2-cycle SCL spike during a write is ignored and the byte value is unchanged.
